// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if -- request/response bundle for the alu_pipe block.
//
// Signals
//   in_valid / in_ready : request handshake, transfer when both are high
//   op, a, b            : opcode and operands, sampled on transfer
//   out_valid/out_ready : response handshake, consumed when both are high
//   result, out_err     : registered result and illegal-opcode indication
//   flag_n/z/c/v        : registered status flags
//   busy                : high while a multiply iterates
//
// Modports
//   master : request producer / response consumer (drives op, a, b, handshakes)
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface alu_pipe_if #(
   parameter int WIDTH = 16
) ();

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             out_err;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, out_err,
      input  flag_n, flag_z, flag_c, flag_v, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, out_err,
      output flag_n, flag_z, flag_c, flag_v, busy
   );

endinterface

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- handshaked ALU with registered result and N/Z/C/V flags.
//
// Ports
//   clk   : single clock, all state on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_pipe_if.slave (request, response, flags, busy)
//
// Opcodes: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT,
//          8 SHL, 9 SHR, A ASR, B CMP, C MUL (optional), D-F reserved.
// Ops 0-B complete in one cycle; the response is held in HOLD until consumed.
// Reserved opcodes return result 0 with out_err set and leave the flags alone.
//
// Configuration
//   ALU_PIPE_MUL_EN : when defined, op C is an unsigned shift-add multiply that
//                     iterates WIDTH cycles in state MUL with busy high. When
//                     undefined, op C is treated as a reserved opcode and busy
//                     is tied low.
// -----------------------------------------------------------------------------
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);

   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_ADC = 4'h2;
   localparam logic [3:0] OP_SBC = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_ASR = 4'hA;
   localparam logic [3:0] OP_CMP = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef ALU_PIPE_MUL_EN
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam int         CNT_W   = $clog2(WIDTH);
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             flag_n_q, flag_n_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_c_q, flag_c_d;
   logic             flag_v_q, flag_v_d;

`ifdef ALU_PIPE_MUL_EN
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               is_mul;
`endif

   logic xfer;

   // ---------------------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] a, b;
   logic [WIDTH:0]   sum_ext, dif_ext;
   logic             add_cin, sub_cin;
   logic [WIDTH-1:0] alu_val, alu_res;
   logic             alu_c, alu_v, alu_err;

   assign a = bus.a;
   assign b = bus.b;

   // Subtraction is a + ~b + 1; with the carry-in replaced by the stored carry,
   // SBC subtracts the inverted carry as a borrow. Carry out then reads as
   // "no borrow", which is exactly the C flag for SUB/SBC/CMP.
   assign add_cin = (bus.op == OP_ADC) & flag_c_q;
   assign sub_cin = (bus.op == OP_SBC) ? flag_c_q : 1'b1;
   assign sum_ext = {1'b0, a} + {1'b0, b}  + (WIDTH+1)'(add_cin);
   assign dif_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(sub_cin);

   // NOTE: every output of a combinational block gets a default on entry so no
   // path through the case statement leaves a variable unassigned (no latches).
   always_comb begin : alu_comb
      alu_val = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      unique case (bus.op)
         OP_ADD, OP_ADC: begin
            alu_val = sum_ext[MSB:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            alu_val = dif_ext[MSB:0];
            alu_c   = dif_ext[WIDTH];
            alu_v   = (a[MSB] != b[MSB]) && (dif_ext[MSB] != a[MSB]);
         end
         OP_AND: alu_val = a & b;
         OP_OR:  alu_val = a | b;
         OP_XOR: alu_val = a ^ b;
         OP_NOT: alu_val = ~a;
         OP_SHL: begin
            alu_val = {a[MSB-1:0], 1'b0};
            alu_c   = a[MSB];
         end
         OP_SHR: begin
            alu_val = {1'b0, a[MSB:1]};
            alu_c   = a[0];
         end
         OP_ASR: begin
            alu_val = {a[MSB], a[MSB:1]};
            alu_c   = a[0];
         end
         // The multiplier, when built in, is steered away by the FSM before
         // this result is used, so op C looks reserved from the ALU's view.
         OP_MUL:  alu_err = 1'b1;
         default: alu_err = 1'b1;
      endcase
      // CMP publishes flags of a-b but hands back a unchanged.
      alu_res = (bus.op == OP_CMP) ? a : alu_val;
   end

   // ---------------------------------------------------------------------------
   // Handshake and next-state logic
   // ---------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign xfer          = bus.in_valid && bus.in_ready;

`ifdef ALU_PIPE_MUL_EN
   assign is_mul   = (bus.op == OP_MUL);
   assign bus.busy = (state_q == ST_MUL);
`else
   assign bus.busy = 1'b0;
`endif

   always_comb begin : fsm_comb
      state_d  = state_q;
      result_d = result_q;
      err_d    = err_q;
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
      flag_v_d = flag_v_q;
`ifdef ALU_PIPE_MUL_EN
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
`endif
      unique case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (xfer) begin
`ifdef ALU_PIPE_MUL_EN
               if (is_mul) begin
                  state_d  = ST_MUL;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
               end else
`endif
               begin
                  state_d  = ST_HOLD;
                  result_d = alu_res;
                  err_d    = alu_err;
                  if (!alu_err) begin
                     flag_n_d = alu_val[MSB];
                     flag_z_d = (alu_val == '0);
                     flag_c_d = alu_c;
                     flag_v_d = alu_v;
                  end
               end
            end else if (state_q == ST_HOLD && bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
`ifdef ALU_PIPE_MUL_EN
         ST_MUL: begin
            // One partial product per cycle; the final iteration writes the
            // response directly so out_valid rises WIDTH cycles after entry.
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = ST_HOLD;
               cnt_d    = '0;
               result_d = acc_d[MSB:0];
               err_d    = 1'b0;
               flag_n_d = acc_d[MSB];
               flag_z_d = (acc_d[MSB:0] == '0);
               flag_c_d = |acc_d[2*WIDTH-1:WIDTH];
               flag_v_d = 1'b0;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         err_q    <= 1'b0;
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         err_q    <= err_d;
         flag_n_q <= flag_n_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
         flag_v_q <= flag_v_d;
`ifdef ALU_PIPE_MUL_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

`ifdef ALU_PIPE_MUL_EN
   // NOTE: the multiply datapath is deliberately left out of reset; it is fully
   // loaded on every multiply transfer and nothing observes it outside MUL.
   always_ff @(posedge clk) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
   end
`endif

   assign bus.result = result_q;
   assign bus.out_err = err_q;
   assign bus.flag_n = flag_n_q;
   assign bus.flag_z = flag_z_q;
   assign bus.flag_c = flag_c_q;
   assign bus.flag_v = flag_v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- directed bench for alu_pipe (WIDTH=16) with a response
// scoreboard. Expected responses come from an arithmetic reference model run
// when each request transfers; a monitor pops and compares on consumption.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] res;
      logic         err;
      logic         n;
      logic         z;
      logic         c;
      logic         v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   exp_t sb_q[$];
   logic m_n, m_z, m_c, m_v;

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic ovf(input int s);
      return (s > 32767) || (s < -32768);
   endfunction

   // Reference model: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int ua, ub, sa, sb, r, sr, bor;
      longint p;
      logic [W-1:0] val;
      logic signed [W-1:0] sa_v;
      logic c, v, err;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      sa_v = a;
      val = '0; c = 1'b0; v = 1'b0; err = 1'b0;
      case (op)
         4'h0: begin r = ua + ub; sr = sa + sb; val = r[W-1:0]; c = r > 65535; v = ovf(sr); end
         4'h2: begin
            r = ua + ub + int'(m_c); sr = sa + sb + int'(m_c);
            val = r[W-1:0]; c = r > 65535; v = ovf(sr);
         end
         4'h1, 4'hB: begin r = ua - ub; sr = sa - sb; val = r[W-1:0]; c = ua >= ub; v = ovf(sr); end
         4'h3: begin
            bor = m_c ? 0 : 1;
            r = ua - ub - bor; sr = sa - sb - bor;
            val = r[W-1:0]; c = ua >= ub + bor; v = ovf(sr);
         end
         4'h4: val = a & b;
         4'h5: val = a | b;
         4'h6: val = a ^ b;
         4'h7: val = ~a;
         4'h8: begin val = a << 1; c = a[W-1]; end
         4'h9: begin val = a >> 1; c = a[0]; end
         4'hA: begin val = sa_v >>> 1; c = a[0]; end
`ifdef ALU_PIPE_MUL_EN
         4'hC: begin p = longint'(ua) * longint'(ub); val = p[W-1:0]; c = (p >> W) != 0; end
`endif
         default: err = 1'b1;
      endcase
      if (!err) begin
         m_n = val[W-1]; m_z = (val == '0); m_c = c; m_v = v;
      end
      e.res = err ? '0 : ((op == 4'hB) ? a : val);
      e.err = err;
      e.n = m_n; e.z = m_z; e.c = m_c; e.v = m_v;
      return e;
   endfunction

   // Response monitor: a response is consumed on the edge after a negedge that
   // sees out_valid && out_ready.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_result", 64'(bus.result), 64'(e.res));
            check("sb_err",    64'(bus.out_err), 64'(e.err));
            check("sb_n",      64'(bus.flag_n), 64'(e.n));
            check("sb_z",      64'(bus.flag_z), 64'(e.z));
            check("sb_c",      64'(bus.flag_c), 64'(e.c));
            check("sb_v",      64'(bus.flag_v), 64'(e.v));
         end
      end
   end

   // Present a request and hold it until it transfers; returns #1 after the
   // transfer edge with in_valid dropped.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int waited;
      bus.in_valid = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      waited = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (bus.in_ready !== 1'b1) begin
         check("send_timeout_in_ready", 64'(bus.in_ready), 64'd1);
      end else begin
         sb_q.push_back(model(op, a, b));
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int t0, n;
      bus.in_valid = 1'b0;
      bus.op = '0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      m_n = 0; m_z = 0; m_c = 0; m_v = 0;

      // Reset state
      tick(3);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy",      64'(bus.busy), 64'd0);
      check("rst_result",    64'(bus.result), 64'd0);
      check("rst_err",       64'(bus.out_err), 64'd0);
      check("rst_flags",     64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'd0);
      rst_n = 1'b1;
      tick(1);
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      // ADD overflow into the sign bit
      bus.out_ready = 1'b1;
      send(4'h0, 16'h7FFF, 16'h0001);
      check("add_out_valid_latency", 64'(bus.out_valid), 64'd1);
      check("add_result", 64'(bus.result), 64'h8000);
      check("add_nzcv",   64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'b1001);

      // SUB with borrow, then SBC consuming that borrow
      send(4'h1, 16'h0003, 16'h0005);
      check("sub_result", 64'(bus.result), 64'hFFFE);
      check("sub_c",      64'(bus.flag_c), 64'd0);
      check("sub_n",      64'(bus.flag_n), 64'd1);
      send(4'h3, 16'h0010, 16'h0001);
      check("sbc_result", 64'(bus.result), 64'h000E);
      check("sbc_c",      64'(bus.flag_c), 64'd1);

      // Back-to-back ADD stream, one transfer per cycle
      t0 = cyc;
      for (int i = 0; i < 6; i++) send(4'h0, 16'(i * 16'h1111), 16'(16'hF000 + i));
      check("stream_cycles", 64'(cyc - t0), 64'd6);
      drain();
      tick(2);

      // Stall: response held for two cycles with out_ready low
      bus.out_ready = 1'b0;
      send(4'h2, 16'hFFFF, 16'h0001);
      for (int k = 0; k < 2; k++) begin
         tick(1);
         check("stall_out_valid", 64'(bus.out_valid), 64'd1);
         check("stall_in_ready",  64'(bus.in_ready), 64'd0);
         check("stall_result",    64'(bus.result), 64'(sb_q[0].res));
         check("stall_flags",     64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}),
               64'({sb_q[0].n, sb_q[0].z, sb_q[0].c, sb_q[0].v}));
      end
      bus.out_ready = 1'b1;
      drain();

      // Logic, shift, compare and reserved opcodes
      send(4'h4, 16'hF0F0, 16'h3C3C);
      send(4'h5, 16'hF0F0, 16'h3C3C);
      send(4'h6, 16'hF0F0, 16'hF0F0);
      send(4'h7, 16'h00FF, 16'h0000);
      send(4'h8, 16'h8001, 16'h0000);
      send(4'h9, 16'h0001, 16'h0000);
      send(4'hA, 16'h8002, 16'h0000);
      send(4'hB, 16'h0005, 16'h0005);
      check("cmp_result_is_a", 64'(bus.result), 64'h0005);
      send(4'hB, 16'h0003, 16'h0005);
      send(4'hD, 16'h1234, 16'h5678);
      check("reserved_err", 64'(bus.out_err), 64'd1);
      send(4'hE, 16'hFFFF, 16'hFFFF);
      send(4'hF, 16'h0000, 16'h0000);
      send(4'h0, 16'h0001, 16'h0001);
      check("legal_err_clear", 64'(bus.out_err), 64'd0);
      for (int i = 0; i < 24; i++) send(4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom));
      drain();

      // Multiply latency and result
      send(4'hC, 16'h0100, 16'h0100);
      n = 1;
      while (bus.out_valid !== 1'b1 && n < 60) begin
         tick(1);
         n++;
      end
`ifdef ALU_PIPE_MUL_EN
      check("mul_latency", 64'(n), 64'd17);
      check("mul_c",       64'(bus.flag_c), 64'd1);
      check("mul_z",       64'(bus.flag_z), 64'd1);
`else
      check("mul_latency", 64'(n), 64'd1);
      check("mul_err",     64'(bus.out_err), 64'd1);
`endif
      check("mul_result", 64'(bus.result), 64'd0);
      drain();

      // Reset in the middle of a multiply
      send(4'h0, 16'h7FFF, 16'h7FFF);
      send(4'hC, 16'h1234, 16'h0011);
      tick(4);
`ifdef ALU_PIPE_MUL_EN
      check("mul_busy_cycle5", 64'(bus.busy), 64'd1);
`else
      check("mul_busy_cycle5", 64'(bus.busy), 64'd0);
`endif
      rst_n = 1'b0;
      sb_q.delete();
      m_n = 0; m_z = 0; m_c = 0; m_v = 0;
      tick(1);
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_busy",      64'(bus.busy), 64'd0);
      check("abort_result",    64'(bus.result), 64'd0);
      check("abort_flags",     64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'd0);
      rst_n = 1'b1;
      tick(1);
      check("abort_in_ready", 64'(bus.in_ready), 64'd1);
      tick(20);
      check("abort_no_stale", 64'(bus.out_valid), 64'd0);

      // Flags after reset feed ADC carry-in as zero
      send(4'h2, 16'h0001, 16'h0001);
      check("post_abort_adc", 64'(bus.result), 64'h0002);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL support any value 4..64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts request; transfer when in_valid && in_ready.
REQ-006 op  input  4  opcode: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR, A ASR, B CMP, C MUL, D-F reserved.
REQ-007 a, b  input  WIDTH  operands, sampled only on transfer.
REQ-008 out_valid  output  1  result/flags valid.
REQ-009 out_ready  input  1  consumer accepts; result consumed when out_valid && out_ready.
REQ-010 result  output  WIDTH  registered result.
REQ-011 out_err  output  1  registered; 1 = illegal opcode for this request.
REQ-012 flag_n, flag_z, flag_c, flag_v  output  1 each  registered status flags.
REQ-013 busy  output  1  high while a multiply iterates.

Function
REQ-014 FSM states SHALL be IDLE, MUL, HOLD; HOLD = result registered, awaiting consumption.
REQ-015 in_ready SHALL equal (state==IDLE) || (state==HOLD && out_ready).
REQ-016 Ops 0-B SHALL complete in one cycle: accepted at edge k -> out_valid=1 with result at edge k+1, state HOLD.
REQ-017 ADD/SUB: a+b / a-b modulo 2^WIDTH; ADC/SBC SHALL add flag_c as carry-in / subtract ~flag_c as borrow, using flag_c as registered at transfer.
REQ-018 Flag C: add = carry out; sub/cmp = 1 when no borrow (a>=b unsigned); SHL = a[WIDTH-1]; SHR/ASR = a[0]; logic ops and NOT = 0.
REQ-019 Flag V: signed overflow for ADD/ADC/SUB/SBC/CMP; 0 for all other ops.
REQ-020 Flags N/Z SHALL reflect the computed value's MSB and all-zero test; CMP SHALL update flags but result SHALL equal a.
REQ-021 Flags SHALL update exactly once per accepted request, on the edge out_valid rises; they hold otherwise.
REQ-022 HOLD with out_ready=0: result, flags, out_err SHALL remain stable; new requests stalled.
REQ-023 HOLD with out_ready=1 and in_valid=1: consumption and new transfer SHALL occur on the same edge (back-to-back, one result per cycle).
REQ-024 HOLD with out_ready=1 and in_valid=0: next state IDLE, out_valid=0.
REQ-025 Reserved opcodes D-F SHALL complete in one cycle with result=0, out_err=1, flags unchanged.
REQ-026 out_err SHALL be 0 for every legal opcode.

Reset
REQ-027 rst_n=0 at an edge SHALL force state IDLE, out_valid=0, busy=0, result=0, out_err=0, all flags 0, multiply counter 0.
REQ-028 Reset SHALL take priority over any transfer, including mid-multiply; an aborted multiply produces no result.
REQ-029 in_ready SHALL be 1 on the first edge after rst_n returns high.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN defined: op C SHALL be unsigned shift-add multiply, state MUL for WIDTH cycles, busy=1, out_valid at edge k+WIDTH+1.
REQ-031 With ALU_PIPE_MUL_EN: result = low WIDTH bits of a*b; flag_c = 1 when high WIDTH bits nonzero; flag_v=0; N/Z on low bits; in_ready=0 during MUL.
REQ-032 Without ALU_PIPE_MUL_EN: op C SHALL behave as a reserved opcode (REQ-025); no multiply logic synthesised; busy tied 0.

Verification (WIDTH=16)
REQ-033 ADD 0x7FFF+0x0001 -> result 0x8000, N=1 Z=0 C=0 V=1, out_valid one cycle after transfer.
REQ-034 SUB 0x0003-0x0005 -> 0xFFFE, C=0 N=1; then SBC 0x0010-0x0001 -> 0x000E, C=1.
REQ-035 Back-to-back ADD stream with out_ready=1 -> one result per cycle; hold out_ready=0 two cycles -> result/flags stable, in_ready=0.
REQ-036 MUL 0x0100*0x0100 with macro -> result 0x0000, C=1, Z=1, out_valid 17 cycles after transfer; without macro -> out_err=1, result 0, flags unchanged.
REQ-037 rst_n=0 during MUL cycle 5 -> next edge out_valid=0, busy=0, flags 0, no stale result after release.
